// File: rtl/mem_access_unit.sv
// Memory-side stage of the multicycle datapath: selects PC or ALUOut, runs a single
// req/ack bus transaction and latches fetched words into IR or MDR.
module mem_access_unit #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iord_i,
    input  logic          mem_write_i,
    input  logic          ir_write_i,
    input  logic          mem_read_i,
    input  logic [AW-1:0] pc_i,
    input  logic [AW-1:0] alu_out_i,
    input  logic [DW-1:0] wdata_i,
    output logic          bus_req_o,
    output logic          bus_we_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_wdata_o,
    input  logic          bus_ack_i,
    input  logic [DW-1:0] bus_rdata_i,
    output logic [DW-1:0] ir_o,
    output logic [DW-1:0] mdr_o,
    output logic          stall_o,
    output logic          done_o,
    output logic          err_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    typedef enum logic [1:0] {K_WRITE, K_FETCH, K_LOAD} kind_t;

    state_t        state_q;
    kind_t         kind_q;
    kind_t         req_kind;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] ir_q;
    logic [DW-1:0] mdr_q;
    logic          req_q;
    logic          we_q;
    logic          stall_q;
    logic          done_q;
    logic          err_q;
    logic          request;
    logic [AW-1:0] sel_addr;

    assign request  = mem_write_i | ir_write_i | mem_read_i;
    assign sel_addr = iord_i ? alu_out_i : pc_i;

    // Store wins over fetch, fetch wins over load.
    always_comb begin
        req_kind = K_LOAD;
        if (mem_write_i)
            req_kind = K_WRITE;
        else if (ir_write_i)
            req_kind = K_FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            kind_q  <= K_LOAD;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (request) begin
                        if (sel_addr[1:0] != 2'b00) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q  <= sel_addr;
                            wdata_q <= wdata_i;
                            kind_q  <= req_kind;
                            req_q   <= 1'b1;
                            we_q    <= (req_kind == K_WRITE);
                            stall_q <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack_i) begin
                        rdata_q <= bus_rdata_i;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        // Abort: the memory never answered within TIMEOUT REQ cycles.
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        err_q   <= 1'b1;
                        stall_q <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    if (kind_q == K_FETCH)
                        ir_q <= rdata_q;
                    else if (kind_q == K_LOAD)
                        mdr_q <= rdata_q;
                    stall_q <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign ir_o        = ir_q;
    assign mdr_o       = mdr_q;
    assign stall_o     = stall_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
endmodule
